router_fsm: RTL



---
 rtl/router_pkg.sv | 26 ++
 rtl/router_fsm.sv | 117 +++++++++++
 2 files changed

// File: rtl/router_pkg.sv
// router_pkg
// Shared types and constants for the router input path. Both the register
// block and router_fsm import this package so the state encoding and the
// default geometry stay in one place.
//   state_t       : 3-bit FSM state encoding
//   RESET_STATE   : state entered on rst
//   DEF_NUM_FIFO  : default number of destination FIFOs
//   DEF_ADDR_W    : default width of the header address field
package router_pkg;

    typedef enum logic [2:0] {
        DA  = 3'd0,   // DECODE_ADDRESS
        LFD = 3'd1,   // LOAD_FIRST_DATA
        LD  = 3'd2,   // LOAD_DATA
        FFS = 3'd3,   // FIFO_FULL_STATE
        LAF = 3'd4,   // LOAD_AFTER_FULL
        LP  = 3'd5,   // LOAD_PARITY
        CPE = 3'd6,   // CHECK_PARITY_ERROR
        WTE = 3'd7    // WAIT_TILL_EMPTY
    } state_t;

    localparam state_t RESET_STATE  = DA;
    localparam int     DEF_NUM_FIFO = 3;
    localparam int     DEF_ADDR_W   = 2;

endpackage

// File: rtl/router_fsm.sv
// router_fsm
// Packet-sequencing controller for the router input path. Decodes the header
// address, then walks the byte register / FIFO write path through header,
// payload, FIFO-full stall and parity states.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   pkt_valid        : source packet valid (low on the parity byte)
//   din              : address field of the current input byte
//   fifo_full        : full flag of the selected FIFO
//   fifo_empty       : per-FIFO empty flags
//   soft_reset       : per-FIFO read-timeout soft resets
//   parity_done      : parity byte captured (register block)
//   low_pkt_valid    : pkt_valid fell while stalled (register block)
//   detect_add .. rst_int_reg : one-hot state strobes
//   write_enb_reg    : FIFO write enable
//   busy             : stall request to the source
//   addr             : latched destination, drives FIFO select
module router_fsm
    import router_pkg::*;
#(
    parameter int NUM_FIFO = DEF_NUM_FIFO,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pkt_valid,
    input  logic [ADDR_W-1:0]   din,
    input  logic                fifo_full,
    input  logic [NUM_FIFO-1:0] fifo_empty,
    input  logic [NUM_FIFO-1:0] soft_reset,
    input  logic                parity_done,
    input  logic                low_pkt_valid,
    output logic                detect_add,
    output logic                lfd_state,
    output logic                ld_state,
    output logic                full_state,
    output logic                laf_state,
    output logic                rst_int_reg,
    output logic                write_enb_reg,
    output logic                busy,
    output logic [ADDR_W-1:0]   addr
);

    // Per-FIFO flags are zero-padded to the full address space so they can be
    // indexed by any din/addr value; out-of-range slots are never selected
    // because avalid filters them and addr only latches valid addresses.
    localparam int              EXT_W      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] NUM_FIFO_W = NUM_FIFO[ADDR_W:0];

    state_t             state, next_state;
    logic [EXT_W-1:0]   empty_ext, sr_ext;
    logic               avalid;

    always_comb begin
        empty_ext = '0;
        sr_ext    = '0;
        empty_ext[NUM_FIFO-1:0] = fifo_empty;
        sr_ext[NUM_FIFO-1:0]    = soft_reset;
    end

    assign avalid = pkt_valid && ({1'b0, din} < NUM_FIFO_W);

    always_comb begin
        next_state = state;
        case (state)
            DA: begin
                if (avalid)
                    next_state = empty_ext[din] ? LFD : WTE;
            end
            LFD: next_state = LD;
            LD: begin
                // fifo_full wins over end-of-packet
                if (fifo_full)       next_state = FFS;
                else if (!pkt_valid) next_state = LP;
            end
            FFS: begin
                if (!fifo_full) next_state = LAF;
            end
            LAF: begin
                if (parity_done)        next_state = DA;
                else if (low_pkt_valid) next_state = LP;
                else                    next_state = LD;
            end
            LP:  next_state = CPE;
            CPE: next_state = fifo_full ? FFS : DA;
            WTE: begin
                if (empty_ext[addr]) next_state = LFD;
            end
            default: next_state = DA;
        endcase
        // Read-timeout on the selected FIFO abandons the packet from anywhere.
        if (state != DA && sr_ext[addr])
            next_state = DA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
            addr  <= '0;
        end else begin
            state <= next_state;
            if (state == DA && avalid)
                addr <= din;
        end
    end

    // Pure state decodes: no input reaches an output combinationally.
    assign detect_add    = (state == DA);
    assign lfd_state     = (state == LFD);
    assign ld_state      = (state == LD);
    assign full_state    = (state == FFS);
    assign laf_state     = (state == LAF);
    assign rst_int_reg   = (state == CPE);
    assign write_enb_reg = (state == LD) || (state == LAF) || (state == LP);
    assign busy          = !((state == DA) || (state == LD));

endmodule
